ram2_stream_ctrl: RTL
=====================

Name: ram2_stream_ctrl

Overview:
Initiator-side controller for the two-port RAM primitive (depth 2^AWIDTH, 1-cycle registered read with enable). It turns an external RAM instance into a streaming FIFO. Port A write is driven from a valid/ready input stream. Port B read is driven by a prefetch engine that feeds a 2-entry output skid buffer, so the output stream sustains 1 word/cycle. Used wherever a streaming operator needs block-RAM buffering deeper than a register FIFO.

Parameters:
DWIDTH, 16, data word width; must equal the RAM DWIDTH.
AWIDTH, 7, RAM address width; RAM depth DEPTH = 2^AWIDTH.

Ports:
clk  input  1  single clock for all logic and the attached RAM
resetn  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of all contents
in_data  input  DWIDTH  input stream data
in_valid  input  1  input stream valid
in_ready  output  1  input stream ready
out_data  output  DWIDTH  output stream data, registered
out_valid  output  1  output stream valid, registered
out_ready  input  1  output stream ready
level  output  AWIDTH+2  words held (RAM + in-flight + skid), registered
ram_wrena  output  1  to RAM wrena
ram_wraddra  output  AWIDTH  to RAM wraddra
ram_dia  output  DWIDTH  to RAM dia
ram_rdenb  output  1  to RAM rdenb
ram_rdaddrb  output  AWIDTH  to RAM rdaddrb
ram_dob  input  DWIDTH  from RAM dob, valid the cycle after ram_rdenb
(The integrator ties RAM wrenb and rdena to 0.)

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on resetn.
- Reset values while resetn=0: wr_ptr=rd_ptr=0 (AWIDTH+1 bits each), inflight=0, skid empty, out_valid=0, out_data=0, level=0, in_ready=0, ram_wrena=0, ram_rdenb=0.
- in_ready = resetn_sync_released & !clear & ((wr_ptr-rd_ptr) != DEPTH). Combinational from registers; it does not depend on in_valid.
- in_fire = in_valid & in_ready.
- ram_wrena = in_fire; ram_wraddra = wr_ptr[AWIDTH-1:0]; ram_dia = in_data. All combinational. wr_ptr increments on in_fire, wrapping modulo 2^(AWIDTH+1).
- Read issue: ram_rdenb = !clear & (rd_ptr != wr_ptr) & (skid_cnt + inflight - out_fire < 2); ram_rdaddrb = rd_ptr[AWIDTH-1:0].
- On issue: rd_ptr++ and inflight<=1; otherwise inflight<=0.
- A word written at edge E is readable by an issue in the cycle after E (no read-during-write hazard, since the pointers differ).
- Capture: when inflight=1, ram_dob is pushed into the skid buffer (2 entries, FIFO order). out_valid = skid non-empty; out_data = skid head.
- out_fire = out_valid & out_ready pops the head. Push and pop in the same cycle are both applied.
- Latency: a word accepted at edge E into an empty block shows out_valid=1 after edge E+2.
- Throughput: with out_ready held at 1 and in_valid at 1, the block accepts and delivers 1 word/cycle with no bubbles.
- Capacity: DEPTH words in RAM + 2 in the skid = DEPTH+2 total with out_ready=0. in_ready falls only when the RAM region is full.
- level: +1 on in_fire, -1 on out_fire, both applied in the same cycle (net 0). Registered. Range 0..DEPTH+2.
- clear=1, synchronous, wins over all other events:
  - next edge: pointers 0, inflight 0 (the returning ram_dob is discarded), skid empty, level 0, out_valid 0;
  - in_ready=0 and ram_rdenb=0 during the clear cycle.
- Async reset mid-stream: all state drops immediately to the reset values. In-flight data is lost; no partial output.
- Pointer wrap: the full/empty distinction uses the MSB of the AWIDTH+1-bit pointers. Ordering is preserved across any number of wraps.

Test Plan:
- Reset: AWIDTH=3, DWIDTH=16; hold resetn=0 for 3 cycles -> out_valid=0, in_ready=0, level=0, ram_wrena=ram_rdenb=0; after release in_ready=1.
- Single word: push 0xA5A5 at edge E with out_ready=1 -> ram_wrena=1, ram_wraddra=0 at E; ram_rdenb=1, ram_rdaddrb=0 in the next cycle; out_valid=1, out_data=0xA5A5 after E+2; level returns to 0.
- Fill: out_ready=0, push 0..15 continuously -> exactly 10 words accepted, then in_ready=0, level=10, out_data=0; drain -> 0..9 in order, level=0.
- Streaming with wrap: 40 words, in_valid and out_ready at 1 -> one out_fire per cycle once primed, no gaps, order 0..39, pointers wrap 5 times.
- Random backpressure: 200 words, random in_valid/out_ready -> scoreboard match, in_ready never 1 while the RAM region is full, level always equals the accepted-minus-delivered count.
- Clear/reset mid-stream: assert clear with an inflight read and a full skid -> next cycle out_valid=0, level=0; a following push of 0x1234 is the first word out. Repeat with resetn pulsed low asynchronously mid-stream -> same result.

Source files
------------

// File: rtl/ram2_stream_ctrl_if.sv
// Stream-in, stream-out and RAM-port bundle of ram2_stream_ctrl.
// master = the controller, slave = the environment (source, sink and RAM).
interface ram2_stream_ctrl_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7
);
  logic [DWIDTH-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [AWIDTH+1:0] level;
  logic              ram_wrena;
  logic [AWIDTH-1:0] ram_wraddra;
  logic [DWIDTH-1:0] ram_dia;
  logic              ram_rdenb;
  logic [AWIDTH-1:0] ram_rdaddrb;
  logic [DWIDTH-1:0] ram_dob;

  modport master (
    input  in_data, in_valid, out_ready, ram_dob,
    output in_ready, out_data, out_valid, level,
    output ram_wrena, ram_wraddra, ram_dia, ram_rdenb, ram_rdaddrb
  );

  modport slave (
    output in_data, in_valid, out_ready, ram_dob,
    input  in_ready, out_data, out_valid, level,
    input  ram_wrena, ram_wraddra, ram_dia, ram_rdenb, ram_rdaddrb
  );
endinterface

// File: rtl/ram2_stream_ctrl.sv
// Streaming FIFO built around an external two-port RAM with a 1-cycle registered read.
// Reads are prefetched into a 2-entry skid buffer so the output sustains one word per cycle.
module ram2_stream_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  ram2_stream_ctrl_if.master bus
);
  localparam logic [AWIDTH:0]   DEPTH_P = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0]   PTR_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH+1:0] LVL_ONE = (AWIDTH+2)'(1);

  logic              r_rst_done;
  logic [AWIDTH:0]   r_wr_ptr;
  logic [AWIDTH:0]   r_rd_ptr;
  logic              r_inflight;
  logic [1:0]        r_skid_cnt;
  logic [DWIDTH-1:0] r_skid0;
  logic [DWIDTH-1:0] r_skid1;
  logic              r_out_valid;
  logic [AWIDTH+1:0] r_level;

  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [2:0]        w_occ;
  logic              w_rd_issue;
  logic [1:0]        w_skid_cnt_nxt;
  logic [DWIDTH-1:0] w_skid0_nxt;
  logic [DWIDTH-1:0] w_skid1_nxt;

  // Handshakes and read issue; w_occ is the skid occupancy the issued word will land in.
  always_comb begin
    w_in_ready = r_rst_done & ~clear & ((r_wr_ptr - r_rd_ptr) != DEPTH_P);
    w_in_fire  = bus.in_valid & w_in_ready;
    w_out_fire = r_out_valid & bus.out_ready;
    w_occ      = {1'b0, r_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_out_fire};
    w_rd_issue = ~clear & (r_rd_ptr != r_wr_ptr) & (w_occ < 3'd2);
  end

  // Skid buffer next state: push returning RAM data, pop the head on out_fire.
  always_comb begin
    w_skid_cnt_nxt = r_skid_cnt;
    w_skid0_nxt    = r_skid0;
    w_skid1_nxt    = r_skid1;
    case (r_skid_cnt)
      2'd0: begin
        if (r_inflight) begin
          w_skid0_nxt    = bus.ram_dob;
          w_skid_cnt_nxt = 2'd1;
        end else begin
          w_skid_cnt_nxt = 2'd0;
        end
      end
      2'd1: begin
        if (r_inflight && w_out_fire) begin
          w_skid0_nxt = bus.ram_dob;
        end else if (r_inflight) begin
          w_skid1_nxt    = bus.ram_dob;
          w_skid_cnt_nxt = 2'd2;
        end else if (w_out_fire) begin
          w_skid_cnt_nxt = 2'd0;
        end else begin
          w_skid_cnt_nxt = 2'd1;
        end
      end
      2'd2: begin
        // A push into a full skid cannot happen: the issue gate reserves its slot.
        if (w_out_fire) begin
          w_skid0_nxt = r_skid1;
          if (r_inflight) begin
            w_skid1_nxt = bus.ram_dob;
          end else begin
            w_skid_cnt_nxt = 2'd1;
          end
        end else begin
          w_skid_cnt_nxt = 2'd2;
        end
      end
      default: begin
        w_skid_cnt_nxt = 2'd0;
      end
    endcase
  end

  // State registers; clear flushes everything except the reset-release flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rst_done  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_inflight  <= 1'b0;
      r_skid_cnt  <= 2'd0;
      r_skid0     <= '0;
      r_skid1     <= '0;
      r_out_valid <= 1'b0;
      r_level     <= '0;
    end else if (clear) begin
      r_rst_done  <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_inflight  <= 1'b0;
      r_skid_cnt  <= 2'd0;
      r_skid0     <= '0;
      r_skid1     <= '0;
      r_out_valid <= 1'b0;
      r_level     <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_in_fire) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_inflight  <= w_rd_issue;
      r_skid_cnt  <= w_skid_cnt_nxt;
      r_skid0     <= w_skid0_nxt;
      r_skid1     <= w_skid1_nxt;
      r_out_valid <= (w_skid_cnt_nxt != 2'd0);
      case ({w_in_fire, w_out_fire})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.ram_wrena   = w_in_fire;
  assign bus.ram_wraddra = r_wr_ptr[AWIDTH-1:0];
  assign bus.ram_dia     = bus.in_data;
  assign bus.ram_rdenb   = w_rd_issue;
  assign bus.ram_rdaddrb = r_rd_ptr[AWIDTH-1:0];
  assign bus.out_data    = r_skid0;
  assign bus.out_valid   = r_out_valid;
  assign bus.level       = r_level;
endmodule
